uart_cmd_master: RTL and testbench

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_pkg.sv | 14 +
 rtl/uart_byte_rx.sv | 73 +++++++
 rtl/uart_cmd_master.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, FSM encodings and debug struct for the UART command master.
package uart_cmd_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

  typedef struct packed {
    state_t    cmd;
    rx_state_t rx;
  } dbg_t;
endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchroniser, start re-check at half bit, centre sampling.
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  output logic [7:0] data,
  output logic      byte_valid,
  output logic      frame_err,
  output rx_state_t state
);
  localparam int CW = $clog2(DIV);

  rx_state_t      nxt;
  logic           s1, s2, prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           done_bit;

  assign done_bit = (cnt == CW'(DIV - 1));
  assign data     = shreg;

  always_comb begin
    nxt        = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE:  if (prev && !s2) nxt = RX_START;
      RX_START: if (cnt == CW'(DIV / 2 - 1)) nxt = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (done_bit && bit_idx == 3'd7) nxt = RX_STOP;
      RX_STOP: begin
        if (done_bit) begin
          nxt        = RX_IDLE;
          byte_valid = s2;
          frame_err  = !s2;
        end
      end
      default: nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      prev    <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      s1    <= rxd;
      s2    <= s1;
      prev  <= s2;
      state <= nxt;
      // Counter restarts on every state change and at each data-bit boundary.
      if (state == RX_IDLE || nxt != state || (state == RX_DATA && done_bit))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == RX_START) begin
        bit_idx <= '0;
      end else if (state == RX_DATA && done_bit) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {s2, shreg[7:1]};
      end
    end
  end
endmodule

// File: rtl/uart_cmd_master.sv
// Serial command master: sends read/write frames over 8N1 UART and collects the reply.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int TIMEOUT = 2000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        busy,
  output dbg_t        dbg
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int TW  = $clog2(TIMEOUT + 1);

  // Handshake: a command transfers on a rising edge with req_valid and req_ready both high;
  // req_ready is high only in IDLE, so requests outside IDLE are neither taken nor queued.

  state_t         state, nxt;
  rx_state_t      rx_st;
  logic [BW-1:0]  baud_cnt;
  logic [3:0]     bit_idx;
  logic [2:0]     byte_idx, last_byte;
  logic [9:0]     tx_sr;
  logic [39:0]    frame;
  logic           is_write;
  logic [TW-1:0]  timer;
  logic           rsp_cnt;
  logic [7:0]     rsp_hi;
  logic [7:0]     rx_data;
  logic           rx_valid, rx_ferr;
  logic           bit_end, byte_end, timeout, rx_ok, complete;

  uart_byte_rx #(.DIV(DIV)) u_rx (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .rxd        (uart_rxd),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr),
    .state      (rx_st)
  );

  assign bit_end  = (baud_cnt == BW'(DIV - 1));
  assign byte_end = bit_end && (bit_idx == 4'd9);
  assign timeout  = (timer == TW'(TIMEOUT - 1));
  assign rx_ok    = (state == WAIT_RSP) && rx_valid && !rx_ferr;
  assign complete = rx_ok && (is_write || rsp_cnt);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  // Combinational from the async-reset state so the line idles high the instant reset asserts.
  assign uart_txd  = (state == SEND) ? tx_sr[0] : 1'b1;
  assign dbg       = '{cmd: state, rx: rx_st};

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (req_valid) nxt = SEND;
      SEND:     if (byte_end && byte_idx == last_byte) nxt = WAIT_RSP;
      WAIT_RSP: if (complete || timeout) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      last_byte <= '0;
      tx_sr     <= '1;
      frame     <= '0;
      is_write  <= 1'b0;
      timer     <= '0;
      rsp_cnt   <= 1'b0;
      rsp_hi    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_write  <= req_write;
            tx_sr     <= {1'b1, (req_write ? OP_WRITE : OP_READ), 1'b0};
            frame     <= {req_addr, req_wdata};
            last_byte <= req_write ? 3'd5 : 3'd3;
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            timer     <= '0;
            rsp_cnt   <= 1'b0;
          end
        end
        SEND: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
              // Next byte follows the stop bit with no idle gap.
              bit_idx  <= '0;
              byte_idx <= byte_idx + 3'd1;
              tx_sr    <= {1'b1, frame[39:32], 1'b0};
              frame    <= {frame[31:0], 8'h00};
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_sr   <= {1'b1, tx_sr[9:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        WAIT_RSP: begin
          timer <= timer + 1'b1;
          // A good final byte beats a timeout landing in the same cycle.
          if (complete) begin
            rsp_rdata <= is_write ? 16'h0000 : {rsp_hi, rx_data};
            rsp_err   <= is_write && (rx_data != RSP_ACK);
          end else if (timeout) begin
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b1;
          end else if (rx_ok) begin
            rsp_hi  <= rx_data;
            rsp_cnt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: frame bit timing, responses, timeouts, stray bytes, reset abort.
module tb_uart_cmd_master;
  import uart_cmd_pkg::*;

  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 62500;
  localparam int DIV     = 16;
  localparam int TIMEOUT = 3000;

  logic        sys_clk, sys_rst_n;
  logic        req_valid, req_ready, req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        uart_txd, uart_rxd, busy;
  dbg_t        dbg;

  uart_cmd_master #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .uart_txd  (uart_txd),
    .uart_rxd  (uart_rxd),
    .busy      (busy),
    .dbg       (dbg)
  );

  // Clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int rsp_seen = 0;
  int rsp_cyc = 0;
  int entry_cyc = 0;
  int lat;
  int lows;
  logic [16:0] exp_q[$];

  always @(posedge sys_clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each rsp_valid pulse must match the next expected {err, rdata}.
  always @(negedge sys_clk) begin
    if (sys_rst_n && rsp_valid) begin
      rsp_seen <= rsp_seen + 1;
      rsp_cyc  <= cycle_cnt;
      check("rsp_expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rsp_payload", {rsp_err, rsp_rdata}, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic send_cmd(input logic wr, input logic [23:0] a, input logic [15:0] d, input bit hold);
    @(negedge sys_clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge sys_clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [47:0] bytes, input int n);
    int bad;
    int bp, k;
    logic [7:0] b;
    logic e;
    bad = 0;
    for (int c = 0; c < n * 10 * DIV; c++) begin
      @(negedge sys_clk);
      bp = c / DIV;
      k  = bp % 10;
      b  = bytes[47 - 8 * (bp / 10) -: 8];
      e  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k - 1];
      if (uart_txd !== e) bad++;
    end
    entry_cyc = cycle_cnt + 1;
    check(tag, bad, 0);
  endtask

  task automatic uart_send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (DIV) @(negedge sys_clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input int target, output int latency);
    int n;
    n = 0;
    while (rsp_seen < target && n < TIMEOUT + 200) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, rsp_seen, target);
    latency = rsp_cyc - entry_cyc;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_txd", uart_txd, 1);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_state", dbg.cmd, IDLE);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Write acknowledged with 0x4B
    exp_q.push_back({1'b0, 16'h0000});
    send_cmd(1'b1, 24'h012345, 16'hBEEF, 1'b0);
    check("wr_busy_in_send", busy, 1);
    check_frame("wr_frame", 48'h57_01_23_45_BE_EF, 6);
    @(negedge sys_clk);
    check("wr_state_wait", dbg.cmd, WAIT_RSP);
    uart_send_byte(8'h4B, 1'b1);
    wait_rsp("wr_rsp_seen", 1, lat);
    check("wr_rsp_before_timeout", 32'(lat < TIMEOUT), 1);
    check("wr_err_hold", rsp_err, 0);
    repeat (DIV) @(negedge sys_clk);
    check("wr_single_pulse", rsp_seen, 1);
    check("wr_back_idle", dbg.cmd, IDLE);
    check("wr_ready_again", req_ready, 1);

    // Read answered 0x12 0x34
    exp_q.push_back({1'b0, 16'h1234});
    send_cmd(1'b0, 24'h000010, 16'h0000, 1'b0);
    check_frame("rd_frame", 48'h52_00_00_10_0000, 4);
    uart_send_byte(8'h12, 1'b1);
    uart_send_byte(8'h34, 1'b1);
    wait_rsp("rd_rsp_seen", 2, lat);
    check("rd_rdata_hold", rsp_rdata, 16'h1234);
    check("rd_err_hold", rsp_err, 0);
    repeat (DIV) @(negedge sys_clk);
    check("rd_single_pulse", rsp_seen, 2);

    // Read with no response: timeout exactly TIMEOUT cycles after WAIT_RSP entry
    exp_q.push_back({1'b1, 16'h0000});
    send_cmd(1'b0, 24'hABCDEF, 16'h0000, 1'b0);
    check_frame("to_frame", 48'h52_AB_CD_EF_0000, 4);
    wait_rsp("to_rsp_seen", 3, lat);
    check("to_latency", lat, TIMEOUT);
    check("to_err", rsp_err, 1);
    check("to_rdata", rsp_rdata, 0);

    // Write answered 0x4B with a framing error: byte dropped, timeout
    exp_q.push_back({1'b1, 16'h0000});
    send_cmd(1'b1, 24'h000001, 16'h5555, 1'b0);
    check_frame("fe_frame", 48'h57_00_00_01_55_55, 6);
    uart_send_byte(8'h4B, 1'b0);
    wait_rsp("fe_rsp_seen", 4, lat);
    check("fe_latency", lat, TIMEOUT);
    check("fe_err", rsp_err, 1);

    // Write answered 0x4E: immediate error
    exp_q.push_back({1'b1, 16'h0000});
    send_cmd(1'b1, 24'hFFFFFF, 16'h0000, 1'b0);
    check_frame("nak_frame", 48'h57_FF_FF_FF_00_00, 6);
    uart_send_byte(8'h4E, 1'b1);
    wait_rsp("nak_rsp_seen", 5, lat);
    check("nak_before_timeout", 32'(lat < TIMEOUT), 1);
    check("nak_err", rsp_err, 1);

    // Stray byte in IDLE is discarded
    uart_send_byte(8'hAA, 1'b1);
    repeat (4 * DIV) @(negedge sys_clk);
    check("stray_no_rsp", rsp_seen, 5);
    check("stray_idle", busy, 0);

    // Read with req_valid held through SEND: one frame only
    exp_q.push_back({1'b0, 16'h5678});
    send_cmd(1'b0, 24'h123456, 16'h0000, 1'b1);
    check_frame("hold_frame", 48'h52_12_34_56_0000, 4);
    @(negedge sys_clk);
    check("hold_state_wait", dbg.cmd, WAIT_RSP);
    req_valid = 1'b0;
    uart_send_byte(8'h56, 1'b1);
    uart_send_byte(8'h78, 1'b1);
    wait_rsp("hold_rsp_seen", 6, lat);
    check("hold_rdata", rsp_rdata, 16'h5678);
    lows = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("hold_no_second_frame", lows, 0);
    check("hold_idle", dbg.cmd, IDLE);

    // Reset mid-way through the third byte (addr[15:8] = 0x00, so data bits are 0)
    send_cmd(1'b1, 24'h120034, 16'h1111, 1'b0);
    repeat (23 * DIV + DIV / 2) @(negedge sys_clk);
    check("rst_mid_txd_low", uart_txd, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_txd_high", uart_txd, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", dbg.cmd, IDLE);
    check("rst_mid_rdata", rsp_rdata, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_rel_ready", req_ready, 1);
    lows = 0;
    for (int c = 0; c < 2 * DIV; c++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("rst_rel_line_idle", lows, 0);
    check("rst_rel_no_rsp", rsp_seen, 6);

    // Final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
